// File: rtl/usb_pkg.sv
// usb_pkg: USB state and packet-type enums plus SYNC/PID constants shared by the rx and tx FSMs
package usb_pkg;
    typedef enum logic [3:0] {IDLE, SYNC, PID, TOKEN, HS, DATA, DCHK, DONE, ERR, DONE_ERR} state_t;
    typedef enum logic [2:0] {PKT_NONE, PKT_OUT, PKT_IN, PKT_DATA0, PKT_ACK, PKT_NAK} rx_pkt_t;
    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam logic [7:0] PID_DATA0 = 8'h3C;
    localparam logic [7:0] PID_OUT   = 8'h1E;
    localparam logic [7:0] PID_IN    = 8'h96;
    localparam logic [7:0] PID_ACK   = 8'h2D;
    localparam logic [7:0] PID_NAK   = 8'hA5;
    function automatic rx_pkt_t pid_type(input logic [7:0] pid);
        return pid == PID_OUT   ? PKT_OUT   :
               pid == PID_IN    ? PKT_IN    :
               pid == PID_DATA0 ? PKT_DATA0 :
               pid == PID_ACK   ? PKT_ACK   :
               pid == PID_NAK   ? PKT_NAK   : PKT_NONE;
    endfunction
endpackage

// File: rtl/rx_byte_delay.sv
// rx_byte_delay: 2-deep byte pipeline; the two youngest bytes (the CRC at EOP) are never evicted
module rx_byte_delay (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       shift,
    input  logic [7:0] din,
    output logic [7:0] d0,
    output logic [1:0] count,
    output logic       evict
);
    logic [7:0] d1;
    assign evict = shift && count == 2'd2;
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            d1    <= '0;
            d0    <= '0;
            count <= '0;
        end else if (shift) begin
            d1    <= din;
            d0    <= d1;
            count <= evict ? count : count + 2'd1;
        end
    end
endmodule

// File: rtl/rx_fsm.sv
// rx_fsm: USB full-speed receive controller; validates SYNC/PID, strips CRC16 from DATA0, reports status
module rx_fsm
    import usb_pkg::*;
#(
    parameter int MAX_DATA     = 64,
    parameter int BYTE_TIMEOUT = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_edge,
    input  logic       byte_valid,
    input  logic [7:0] rx_byte,
    input  logic       eop,
    input  logic       crc_ok,
    input  logic       buffer_full,
    output logic       rcving,
    output rx_pkt_t    rx_packet,
    output logic       rx_data_ready,
    output logic       rx_error,
    output logic       store_rx_data,
    output logic [7:0] rx_packet_data,
    output logic [6:0] rx_data_size,
    output logic       crc_clear,
    output logic       crc_enable
);
    localparam int TW = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO = TW'(BYTE_TIMEOUT);
    localparam logic [6:0] MAXD = 7'(MAX_DATA);

    state_t        state, nxt;
    rx_pkt_t       rx_packet_d;
    logic          start, active, timeout, err, evict, push_bad, push, crc_q;
    logic          rcving_d, rx_data_ready_d, rx_error_d, store_d, crc_clear_d, crc_enable_d;
    logic [7:0]    d0, rx_packet_data_d;
    logic [6:0]    rx_data_size_d;
    logic [1:0]    tok_cnt, line_cnt;
    logic [TW-1:0] tmo_cnt;

    assign start    = state == IDLE && d_edge;
    assign active   = state inside {SYNC, PID, TOKEN, HS, DATA};
    assign timeout  = active && !byte_valid && !eop && tmo_cnt == TMO;
    assign push_bad = evict && (rx_data_size == MAXD || buffer_full);
    assign push     = evict && !push_bad;

    rx_byte_delay u_delay (
        .clk   (clk),
        .rst   (rst),
        .clear (state == IDLE),
        .shift (state == DATA && byte_valid),
        .din   (rx_byte),
        .d0    (d0),
        .count (line_cnt),
        .evict (evict)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rcving         <= 1'b0;
            rx_packet      <= PKT_NONE;
            rx_data_ready  <= 1'b0;
            rx_error       <= 1'b0;
            store_rx_data  <= 1'b0;
            rx_packet_data <= '0;
            rx_data_size   <= '0;
            crc_clear      <= 1'b0;
            crc_enable     <= 1'b0;
            tok_cnt        <= '0;
            tmo_cnt        <= '0;
            crc_q          <= 1'b0;
        end else begin
            state          <= nxt;
            rcving         <= rcving_d;
            rx_packet      <= rx_packet_d;
            rx_data_ready  <= rx_data_ready_d;
            rx_error       <= rx_error_d;
            store_rx_data  <= store_d;
            rx_packet_data <= rx_packet_data_d;
            rx_data_size   <= rx_data_size_d;
            crc_clear      <= crc_clear_d;
            crc_enable     <= crc_enable_d;
            tok_cnt        <= state == TOKEN ? tok_cnt + 2'(byte_valid) : 2'd0;
            tmo_cnt        <= (active && !byte_valid && !eop) ? tmo_cnt + TW'(1) : '0;
            crc_q          <= eop ? crc_ok : crc_q;
        end
    end

    always_comb begin
        nxt = state;
        err = 1'b0;
        case (state)
            IDLE:  nxt = d_edge ? SYNC : IDLE;
            SYNC:  begin
                err = byte_valid && rx_byte != SYNC_BYTE;
                nxt = byte_valid ? PID : SYNC;
            end
            PID:   begin
                err = byte_valid && pid_type(rx_byte) == PKT_NONE;
                nxt = !byte_valid                        ? PID   :
                      pid_type(rx_byte) == PKT_DATA0      ? DATA  :
                      pid_type(rx_byte) inside {PKT_OUT, PKT_IN} ? TOKEN : HS;
            end
            TOKEN: begin
                err = (byte_valid && tok_cnt == 2'd2) || (eop && tok_cnt + 2'(byte_valid) != 2'd2);
                nxt = eop ? DONE : TOKEN;
            end
            HS:    begin
                err = byte_valid;
                nxt = eop ? DONE : HS;
            end
            DATA:  begin
                err = push_bad;
                nxt = eop ? DCHK : DATA;
            end
            DCHK:  begin
                err = line_cnt != 2'd2 || !crc_q;
                nxt = DONE;
            end
            ERR:   nxt = eop ? DONE_ERR : ERR;
            default: nxt = IDLE;
        endcase
        err = err || timeout;
        // once EOP has been seen there is no later EOP to wait for, so skip ERR
        if (err) nxt = (eop || state == DCHK) ? DONE_ERR : ERR;
    end

    always_comb begin
        rcving_d         = start || (state != IDLE && state != DONE && state != DONE_ERR);
        rx_packet_d      = start ? PKT_NONE : (state == PID && byte_valid) ? pid_type(rx_byte) : rx_packet;
        rx_data_ready_d  = state == DCHK && !err;
        rx_error_d       = !start && (rx_error || err);
        store_d          = push;
        rx_packet_data_d = push ? d0 : rx_packet_data;
        rx_data_size_d   = start ? 7'd0 : rx_data_size + 7'(push);
        crc_clear_d      = start;
        crc_enable_d     = state == DATA && byte_valid;
    end
endmodule

// File: tb/tb_rx_fsm.sv
// tb_rx_fsm: table-driven packet vectors plus hand-written corner sequences with a push scoreboard
module tb_rx_fsm;
    logic       clk = 1'b0;
    logic       rst, d_edge, byte_valid, eop, crc_ok, buffer_full;
    logic [7:0] rx_byte;
    logic       rcving, rx_data_ready, rx_error, store_rx_data, crc_clear, crc_enable;
    logic [2:0] rx_packet;
    logic [7:0] rx_packet_data;
    logic [6:0] rx_data_size;

    rx_fsm dut (
        .clk            (clk),
        .rst            (rst),
        .d_edge         (d_edge),
        .byte_valid     (byte_valid),
        .rx_byte        (rx_byte),
        .eop            (eop),
        .crc_ok         (crc_ok),
        .buffer_full    (buffer_full),
        .rcving         (rcving),
        .rx_packet      (rx_packet),
        .rx_data_ready  (rx_data_ready),
        .rx_error       (rx_error),
        .store_rx_data  (store_rx_data),
        .rx_packet_data (rx_packet_data),
        .rx_data_size   (rx_data_size),
        .crc_clear      (crc_clear),
        .crc_enable     (crc_enable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] b;
        int n, crc, pkt, err, size, rdy, en;
    } vec_t;

    vec_t       vecs[14];
    logic [7:0] exp_q[$];
    int         n_chk = 0, n_fail = 0;
    int         rdy_cnt = 0, clr_cnt = 0, en_cnt = 0, r0, c0, e0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // samples DUT at negedge (scoreboard + pulse counters), then returns 1 time unit after posedge
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (store_rx_data) begin
            if (exp_q.size() == 0) chk("push unexpected", {24'h0, rx_packet_data}, 32'hFFFF_FFFF);
            else begin
                e = exp_q.pop_front();
                chk("push data", {24'h0, rx_packet_data}, {24'h0, e});
            end
        end
        rdy_cnt += int'(rx_data_ready);
        clr_cnt += int'(crc_clear);
        en_cnt  += int'(crc_enable);
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        r0 = rdy_cnt; c0 = clr_cnt; e0 = en_cnt;
    endtask

    task automatic start();
        d_edge = 1'b1; tick(); d_edge = 1'b0; tick();
    endtask

    task automatic put(input logic [7:0] b, input logic e, input logic c);
        rx_byte = b; byte_valid = 1'b1; eop = e; crc_ok = c; tick();
        byte_valid = 1'b0; eop = 1'b0; crc_ok = 1'b0; tick();
    endtask

    task automatic end_pkt(input logic c);
        eop = 1'b1; crc_ok = c; tick();
        eop = 1'b0; crc_ok = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{48'h803C1122A0B1, 6, 1, 3, 0, 2, 1, 4};
        vecs[1]  = '{48'h802D00000000, 2, 1, 4, 0, 0, 0, 0};
        vecs[2]  = '{48'h801E12340000, 4, 1, 1, 0, 0, 0, 0};
        vecs[3]  = '{48'h809655660000, 4, 1, 2, 0, 0, 0, 0};
        vecs[4]  = '{48'h80A500000000, 2, 1, 5, 0, 0, 0, 0};
        vecs[5]  = '{48'h000000000000, 1, 1, 0, 1, 0, 0, 0};
        vecs[6]  = '{48'h802D00000000, 2, 1, 4, 0, 0, 0, 0};
        vecs[7]  = '{48'h803C1122A0B1, 6, 0, 3, 1, 2, 0, 4};
        vecs[8]  = '{48'h803CAA000000, 3, 1, 3, 1, 0, 0, 1};
        vecs[9]  = '{48'h801E12345600, 5, 1, 1, 1, 0, 0, 0};
        vecs[10] = '{48'h802D77000000, 3, 1, 4, 1, 0, 0, 0};
        vecs[11] = '{48'h807700000000, 2, 1, 0, 1, 0, 0, 0};
        vecs[12] = '{48'h801E12000000, 3, 1, 1, 1, 0, 0, 0};
        vecs[13] = '{48'h803CA0B10000, 4, 1, 3, 0, 0, 1, 2};

        rst = 1'b1; d_edge = 1'b0; byte_valid = 1'b0; eop = 1'b0; crc_ok = 1'b0;
        buffer_full = 1'b0; rx_byte = 8'h00;
        repeat (3) tick();
        chk("reset rcving", rcving, 0);
        chk("reset rx_packet", rx_packet, 0);
        chk("reset rx_error", rx_error, 0);
        chk("reset store", store_rx_data, 0);
        chk("reset size", rx_data_size, 0);
        chk("reset data", rx_packet_data, 0);
        chk("reset crc_clear", crc_clear, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].n >= 2 && vecs[i].b[47:40] == 8'h80 && vecs[i].b[39:32] == 8'h3C)
                for (int j = 2; j < vecs[i].n - 2; j++) exp_q.push_back(vecs[i].b[47-8*j -: 8]);
            snap();
            start();
            chk($sformatf("v%0d rcving during", i), rcving, 1);
            for (int j = 0; j < vecs[i].n; j++) put(vecs[i].b[47-8*j -: 8], 1'b0, 1'b0);
            end_pkt(vecs[i].crc[0]);
            chk($sformatf("v%0d rx_packet", i), rx_packet, vecs[i].pkt);
            chk($sformatf("v%0d rx_error", i), rx_error, vecs[i].err);
            chk($sformatf("v%0d size", i), rx_data_size, vecs[i].size);
            chk($sformatf("v%0d ready pulses", i), rdy_cnt - r0, vecs[i].rdy);
            chk($sformatf("v%0d crc_clear pulses", i), clr_cnt - c0, 1);
            chk($sformatf("v%0d crc_enable pulses", i), en_cnt - e0, vecs[i].en);
            chk($sformatf("v%0d rcving after", i), rcving, 0);
            chk($sformatf("v%0d queue drained", i), exp_q.size(), 0);
        end

        // ACK: rcving falls exactly 2 clk after eop
        start(); put(8'h80, 0, 0); put(8'h2D, 0, 0);
        eop = 1'b1; tick(); eop = 1'b0;
        chk("hs rcving 1clk", rcving, 1);
        tick();
        chk("hs rcving 2clk", rcving, 0);
        repeat (3) tick();

        // token with 4th byte stays in error until eop
        start(); put(8'h80, 0, 0); put(8'h1E, 0, 0); put(8'h01, 0, 0); put(8'h02, 0, 0); put(8'h03, 0, 0);
        chk("tok4 rx_error", rx_error, 1);
        chk("tok4 rcving held", rcving, 1);
        end_pkt(1'b0);
        chk("tok4 rcving after eop", rcving, 0);

        // 65 payload bytes: first 64 pushed, then overflow error
        snap(); start(); put(8'h80, 0, 0); put(8'h3C, 0, 0);
        for (int k = 0; k < 64; k++) exp_q.push_back(8'(k));
        for (int k = 0; k < 67; k++) put(8'(k), 0, 0);
        chk("ovf rx_error before eop", rx_error, 1);
        end_pkt(1'b1);
        chk("ovf size", rx_data_size, 64);
        chk("ovf no ready", rdy_cnt - r0, 0);
        chk("ovf queue drained", exp_q.size(), 0);

        // byte and eop together, with a stray d_edge mid-packet
        snap(); start(); put(8'h80, 0, 0); put(8'h3C, 0, 0); put(8'h11, 0, 0); put(8'hA0, 0, 0);
        d_edge = 1'b1; tick(); d_edge = 1'b0;
        exp_q.push_back(8'h11);
        put(8'hB1, 1'b1, 1'b1);
        repeat (4) tick();
        chk("same size", rx_data_size, 1);
        chk("same ready", rdy_cnt - r0, 1);
        chk("same crc_clear once", clr_cnt - c0, 1);
        chk("same crc_enable", en_cnt - e0, 3);
        chk("same rx_error", rx_error, 0);

        // buffer_full suppresses the push and errors
        snap(); start(); put(8'h80, 0, 0); put(8'h3C, 0, 0); put(8'h11, 0, 0); put(8'h22, 0, 0);
        buffer_full = 1'b1; put(8'h33, 0, 0); buffer_full = 1'b0;
        end_pkt(1'b1);
        chk("full rx_error", rx_error, 1);
        chk("full size", rx_data_size, 0);
        chk("full no ready", rdy_cnt - r0, 0);

        // no timeout after a 90-cycle gap
        start(); put(8'h80, 0, 0); put(8'h2D, 0, 0);
        repeat (90) tick();
        chk("gap90 rx_error", rx_error, 0);
        end_pkt(1'b0);
        chk("gap90 after", rx_error, 0);

        // timeout after 100 silent cycles
        start(); put(8'h80, 0, 0); put(8'h2D, 0, 0);
        repeat (100) tick();
        chk("tmo rx_error", rx_error, 1);
        chk("tmo rcving held", rcving, 1);
        end_pkt(1'b0);
        chk("tmo rcving after eop", rcving, 0);
        chk("tmo rx_error sticky", rx_error, 1);

        // reset mid-DATA: all outputs zero next cycle, pending byte not pushed
        start(); put(8'h80, 0, 0); put(8'h3C, 0, 0); put(8'h11, 0, 0); put(8'h22, 0, 0);
        exp_q.push_back(8'h11);
        put(8'h33, 0, 0);
        rx_byte = 8'h44; byte_valid = 1'b1; rst = 1'b1; tick();
        byte_valid = 1'b0;
        chk("rst rcving", rcving, 0);
        chk("rst rx_packet", rx_packet, 0);
        chk("rst size", rx_data_size, 0);
        chk("rst data", rx_packet_data, 0);
        chk("rst crc_enable", crc_enable, 0);
        chk("rst store", store_rx_data, 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("final queue drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
